// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC and keeps at most one request in flight
// to instruction memory. Fetched words go into a 2-entry buffer toward decode.
// Branch/jump redirects from execute flush the buffer and drop any in-flight
// response.
// Optional build macro FETCH_PERF_CNT_EN adds the perf_fetched and
// perf_flushed event counters.
module fetch_sequencer #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_flushed,
`endif
   output logic            misalign_err
);

   // REQ may issue a request, WAIT owns one outstanding request,
   // DISCARD owes memory one response that must be thrown away.
   typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DISCARD} state_t;

   state_t          state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] outstandingPc_q;
   logic [1:0]      count_q;
   logic [XLEN-1:0] headInstr_q;
   logic [XLEN-1:0] headPc_q;
   logic [XLEN-1:0] tailInstr_q;
   logic [XLEN-1:0] tailPc_q;

   logic [1:0]      count_d;
   logic [1:0]      countAfterPop;
   logic            pop;
   logic            push;
   logic            grant;
   logic            stillOutstanding;
   logic [XLEN-1:0] redirectPc;

   // The buffer head is visible to decode straight from the registers.
   // When the buffer is empty the head registers keep their last value.
   assign mem_addr = pc_q;
   assign if_valid = (count_q != 2'd0);
   assign if_instr = headInstr_q;
   assign if_pc    = headPc_q;

   // Handshake decode and flow control. mem_req cannot be registered: it has
   // to see this cycle's decode pop so that a full buffer can still issue
   // a request in the same cycle that decode frees a slot.
   always_comb begin
      pop              = 1'b0;
      countAfterPop    = count_q;
      mem_req          = 1'b0;
      grant            = 1'b0;
      push             = 1'b0;
      count_d          = count_q;
      stillOutstanding = 1'b0;
      redirectPc       = {redirect_target[XLEN-1:2], 2'b00};
      misalign_err     = 1'b0;

      pop              = (count_q != 2'd0) && if_ready;
      countAfterPop    = count_q - {1'b0, pop};
      mem_req          = !reset && (state_q == ST_REQ) && !redirect_valid && !countAfterPop[1];
      grant            = mem_req && mem_gnt;
      push             = (state_q == ST_WAIT) && mem_rvalid && !redirect_valid;
      count_d          = redirect_valid ? 2'd0 : (countAfterPop + {1'b0, push});
      stillOutstanding = (state_q != ST_REQ) && !mem_rvalid;
      misalign_err     = !reset && redirect_valid && (redirect_target[1:0] != 2'b00);
   end

   // FSM, fetch PC and the 2-entry buffer. A redirect beats everything else;
   // if a response is still owed we park in DISCARD to swallow it, but a
   // response arriving in the redirect cycle itself is simply ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_REQ;
         pc_q            <= RESET_PC;
         outstandingPc_q <= '0;
         count_q         <= 2'd0;
         headInstr_q     <= '0;
         headPc_q        <= '0;
         tailInstr_q     <= '0;
         tailPc_q        <= '0;
      end else begin
         count_q <= count_d;

         if (pop && (count_q == 2'd2)) begin
            headInstr_q <= tailInstr_q;
            headPc_q    <= tailPc_q;
         end

         if (push) begin
            if (countAfterPop == 2'd0) begin
               headInstr_q <= mem_rdata;
               headPc_q    <= outstandingPc_q;
            end else begin
               tailInstr_q <= mem_rdata;
               tailPc_q    <= outstandingPc_q;
            end
         end

         if (redirect_valid) begin
            pc_q    <= redirectPc;
            state_q <= stillOutstanding ? ST_DISCARD : ST_REQ;
         end else begin
            case (state_q)
               ST_REQ: begin
                  if (grant) begin
                     outstandingPc_q <= pc_q;
                     pc_q            <= pc_q + XLEN'(4);
                     state_q         <= ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  if (mem_rvalid) state_q <= ST_REQ;
               end
               ST_DISCARD: begin
                  if (mem_rvalid) state_q <= ST_REQ;
               end
               default: state_q <= ST_REQ;
            endcase
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Event counters: decode handshakes, and work thrown away by redirects.
   // A response already owed in DISCARD was counted by the earlier redirect.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched <= 32'd0;
         perf_flushed <= 32'd0;
      end else begin
         if (pop) perf_fetched <= perf_fetched + 32'd1;
         if (redirect_valid) begin
            perf_flushed <= perf_flushed + 32'(count_q) + ((state_q == ST_WAIT) ? 32'd1 : 32'd0);
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer. Two instances: the default RESET_PC and one
// that starts at 0xFFFFFFFC to exercise PC wrap. Expected grant addresses and
// decode deliveries are queued by the stimulus and consumed by monitors.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirectValid;
   logic [31:0] redirectTarget;
   logic        memReq;
   logic [31:0] memAddr;
   logic        memGnt;
   logic        memRvalid;
   logic [31:0] memRdata;
   logic        ifValid;
   logic        ifReady;
   logic [31:0] ifInstr;
   logic [31:0] ifPc;
   logic        misalignErr;

   logic        wRedirectValid  = 1'b0;
   logic [31:0] wRedirectTarget = 32'd0;
   logic        wMemReq;
   logic [31:0] wMemAddr;
   logic        wMemGnt;
   logic        wMemRvalid;
   logic [31:0] wMemRdata;
   logic        wIfValid;
   logic        wIfReady;
   logic [31:0] wIfInstr;
   logic [31:0] wIfPc;
   logic        wMisalignErr;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int grantCount = 0;
   int hsCount = 0;
   int wGrantCount = 0;
   int wHsCount = 0;
   int memLat = 1;
   logic spacingOn = 1'b0;
   int spacingStart = 0;
   int lastHsCyc = 0;

   logic [31:0] expAddrQ[$];
   logic [31:0] expPcQ[$];
   logic [31:0] wExpAddrQ[$];
   logic [31:0] wExpPcQ[$];

   fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000)) uDut (
      .clk             (clk),
      .reset           (reset),
      .redirect_valid  (redirectValid),
      .redirect_target (redirectTarget),
      .mem_req         (memReq),
      .mem_addr        (memAddr),
      .mem_gnt         (memGnt),
      .mem_rvalid      (memRvalid),
      .mem_rdata       (memRdata),
      .if_valid        (ifValid),
      .if_ready        (ifReady),
      .if_instr        (ifInstr),
      .if_pc           (ifPc),
      .misalign_err    (misalignErr)
   );

   fetch_sequencer #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) uWrap (
      .clk             (clk),
      .reset           (reset),
      .redirect_valid  (wRedirectValid),
      .redirect_target (wRedirectTarget),
      .mem_req         (wMemReq),
      .mem_addr        (wMemAddr),
      .mem_gnt         (wMemGnt),
      .mem_rvalid      (wMemRvalid),
      .mem_rdata       (wMemRdata),
      .if_valid        (wIfValid),
      .if_ready        (wIfReady),
      .if_instr        (wIfInstr),
      .if_pc           (wIfPc),
      .misalign_err    (wMisalignErr)
   );

   // 10 time-unit clock; inputs change 1 unit after the rising edge and
   // outputs are sampled on the falling edge.
   always #5 clk = ~clk;

   // Cycle counter used to measure handshake spacing.
   always @(posedge clk) cyc <= cyc + 1;

   // Instruction word stored at a given address in the memory model.
   function automatic logic [31:0] instrOf(input logic [31:0] a);
      return a ^ 32'hDEAD_0013;
   endfunction

   function automatic int countOf(input int which);
      case (which)
         0: return grantCount;
         1: return hsCount;
         2: return wGrantCount;
         default: return wHsCount;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rdy, input logic gnt, input logic redir, input logic [31:0] tgt);
      @(posedge clk);
      #1;
      ifReady        = rdy;
      memGnt         = gnt;
      redirectValid  = redir;
      redirectTarget = tgt;
   endtask

   // Waits (bounded) until a monitor counter reaches target; returns 1 unit
   // after the rising edge that follows, so inputs can be changed safely.
   task automatic waitFor(input int which, input int target, input string name);
      int n = 0;
      do begin
         @(posedge clk);
         n++;
      end while ((countOf(which) < target) && (n < 300));
      #1;
      checkOutput(name, 32'(countOf(which) >= target), 32'd1);
   endtask

   task automatic applyReset();
      @(posedge clk);
      #1;
      reset = 1'b1; redirectValid = 1'b0; redirectTarget = 32'd0;
      ifReady = 1'b0; memGnt = 1'b0; wIfReady = 1'b0; wMemGnt = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("in reset mem_req", 32'(memReq), 32'd0);
      checkOutput("in reset if_valid", 32'(ifValid), 32'd0);
      checkOutput("in reset misalign_err", 32'(misalignErr), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("after reset if_valid", 32'(ifValid), 32'd0);
      checkOutput("after reset if_pc", ifPc, 32'd0);
      checkOutput("after reset if_instr", ifInstr, 32'd0);
      checkOutput("after reset mem_req", 32'(memReq), 32'd1);
      checkOutput("after reset mem_addr", memAddr, 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Memory model for the main instance: latency memLat cycles after grant.
   logic        sGrant, sReset, pend;
   logic [31:0] sAddr, pendAddr;
   int          latLeft;
   initial begin
      memRvalid = 1'b0; memRdata = 32'd0; pend = 1'b0; pendAddr = 32'd0; latLeft = 0;
      forever begin
         @(negedge clk);
         sGrant = !reset && memReq && memGnt;
         sAddr  = memAddr;
         sReset = reset;
         @(posedge clk);
         #1;
         memRvalid = 1'b0;
         if (sReset) begin
            pend = 1'b0;
         end else begin
            if (sGrant) begin
               pend = 1'b1; pendAddr = sAddr; latLeft = memLat;
            end
            if (pend) begin
               latLeft--;
               if (latLeft == 0) begin
                  memRvalid = 1'b1; memRdata = instrOf(pendAddr); pend = 1'b0;
               end
            end
         end
      end
   end

   // Memory model for the wrap instance: fixed 1-cycle latency.
   logic        wsGrant, wsReset;
   logic [31:0] wsAddr;
   initial begin
      wMemRvalid = 1'b0; wMemRdata = 32'd0;
      forever begin
         @(negedge clk);
         wsGrant = !reset && wMemReq && wMemGnt;
         wsAddr  = wMemAddr;
         wsReset = reset;
         @(posedge clk);
         #1;
         wMemRvalid = wsGrant && !wsReset;
         wMemRdata  = instrOf(wsAddr);
      end
   end

   // Scoreboard monitor for the main instance: grants and decode handshakes.
   logic [31:0] eAddr, ePc;
   always @(negedge clk) begin
      if (!reset && memReq && memGnt) begin
         checkOutput("grant was expected", 32'(expAddrQ.size() != 0), 32'd1);
         if (expAddrQ.size() != 0) begin
            eAddr = expAddrQ.pop_front();
            checkOutput("grant mem_addr", memAddr, eAddr);
         end
         grantCount++;
      end
      if (!reset && ifValid && ifReady) begin
         checkOutput("delivery was expected", 32'(expPcQ.size() != 0), 32'd1);
         if (expPcQ.size() != 0) begin
            ePc = expPcQ.pop_front();
            checkOutput("delivery if_pc", ifPc, ePc);
            checkOutput("delivery if_instr", ifInstr, instrOf(ePc));
         end
         if (spacingOn && (hsCount != spacingStart)) begin
            checkOutput("handshake spacing", 32'(cyc - lastHsCyc), 32'd2);
         end
         lastHsCyc = cyc;
         hsCount++;
      end
   end

   // Scoreboard monitor for the wrap instance.
   logic [31:0] wEAddr, wEPc;
   always @(negedge clk) begin
      if (!reset && wMemReq && wMemGnt) begin
         checkOutput("wrap grant was expected", 32'(wExpAddrQ.size() != 0), 32'd1);
         if (wExpAddrQ.size() != 0) begin
            wEAddr = wExpAddrQ.pop_front();
            checkOutput("wrap grant mem_addr", wMemAddr, wEAddr);
         end
         wGrantCount++;
      end
      if (!reset && wIfValid && wIfReady) begin
         checkOutput("wrap delivery was expected", 32'(wExpPcQ.size() != 0), 32'd1);
         if (wExpPcQ.size() != 0) begin
            wEPc = wExpPcQ.pop_front();
            checkOutput("wrap delivery if_pc", wIfPc, wEPc);
            checkOutput("wrap delivery if_instr", wIfInstr, instrOf(wEPc));
         end
         wHsCount++;
      end
   end

   // Hard stop in case something stalls outside the bounded waits.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   int base, hsBase;
   initial begin
      reset = 1'b1; redirectValid = 1'b0; redirectTarget = 32'd0;
      ifReady = 1'b0; memGnt = 1'b0; wIfReady = 1'b0; wMemGnt = 1'b0;

      // Streaming with 1-cycle memory and decode always ready.
      $display("[TB] streaming fetch");
      applyReset();
      memLat = 1;
      for (int i = 0; i < 4; i++) begin
         expAddrQ.push_back(32'(i * 4));
         expPcQ.push_back(32'(i * 4));
      end
      base = grantCount; hsBase = hsCount;
      spacingStart = hsCount; spacingOn = 1'b1;
      ifReady = 1'b1; memGnt = 1'b1;
      waitFor(0, base + 4, "stream grants");
      memGnt = 1'b0;
      waitFor(1, hsBase + 4, "stream deliveries");
      spacingOn = 1'b0;
      checkOutput("stream addr queue drained", 32'(expAddrQ.size()), 32'd0);
      checkOutput("stream pc queue drained", 32'(expPcQ.size()), 32'd0);

      // Decode stalled: buffer fills after two grants, then drains in order.
      $display("[TB] decode backpressure");
      applyReset();
      expAddrQ.push_back(32'h0); expAddrQ.push_back(32'h4);
      expPcQ.push_back(32'h0);   expPcQ.push_back(32'h4);
      base = grantCount; hsBase = hsCount;
      repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      @(negedge clk);
      checkOutput("stall grant count", 32'(grantCount - base), 32'd2);
      checkOutput("stall mem_req when full", 32'(memReq), 32'd0);
      checkOutput("stall if_valid", 32'(ifValid), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      waitFor(1, hsBase + 2, "stall drain deliveries");
      @(negedge clk);
      checkOutput("empty if_valid", 32'(ifValid), 32'd0);
      checkOutput("empty if_pc holds", ifPc, 32'h4);
      checkOutput("empty if_instr holds", ifInstr, instrOf(32'h4));
      checkOutput("stall addr queue drained", 32'(expAddrQ.size()), 32'd0);
      checkOutput("stall pc queue drained", 32'(expPcQ.size()), 32'd0);

      // Redirect while waiting on 0x8; that response arrives two cycles later.
      $display("[TB] redirect during outstanding request");
      applyReset();
      memLat = 3;
      expAddrQ.push_back(32'h0); expAddrQ.push_back(32'h4);
      expAddrQ.push_back(32'h8); expAddrQ.push_back(32'h100);
      expPcQ.push_back(32'h0); expPcQ.push_back(32'h4); expPcQ.push_back(32'h100);
      base = grantCount; hsBase = hsCount;
      ifReady = 1'b1; memGnt = 1'b1;
      waitFor(0, base + 3, "discard grant of 0x8");
      redirectValid = 1'b1; redirectTarget = 32'h100;
      @(negedge clk);
      checkOutput("discard mem_req in redirect cycle", 32'(memReq), 32'd0);
      checkOutput("discard misalign_err aligned", 32'(misalignErr), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      @(negedge clk);
      checkOutput("discard mem_req while owed", 32'(memReq), 32'd0);
      waitFor(0, base + 4, "discard grant of 0x100");
      memGnt = 1'b0;
      waitFor(1, hsBase + 3, "discard deliveries");
      checkOutput("discard addr queue drained", 32'(expAddrQ.size()), 32'd0);
      checkOutput("discard pc queue drained", 32'(expPcQ.size()), 32'd0);

      // Misaligned redirect with a full buffer.
      $display("[TB] misaligned redirect with full buffer");
      applyReset();
      memLat = 1;
      expAddrQ.push_back(32'h0); expAddrQ.push_back(32'h4); expAddrQ.push_back(32'h200);
      expPcQ.push_back(32'h200);
      base = grantCount; hsBase = hsCount;
      ifReady = 1'b0; memGnt = 1'b1;
      waitFor(0, base + 2, "flush two grants");
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      @(negedge clk);
      checkOutput("flush buffer head valid", 32'(ifValid), 32'd1);
      checkOutput("flush buffer head pc", ifPc, 32'h0);
      checkOutput("flush buffer head instr", ifInstr, instrOf(32'h0));
      checkOutput("flush mem_req when full", 32'(memReq), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h202);
      @(negedge clk);
      checkOutput("flush misalign_err pulse", 32'(misalignErr), 32'd1);
      checkOutput("flush mem_req in redirect cycle", 32'(memReq), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      @(negedge clk);
      checkOutput("flush if_valid cleared", 32'(ifValid), 32'd0);
      checkOutput("flush misalign_err one cycle", 32'(misalignErr), 32'd0);
      checkOutput("flush mem_req restarts", 32'(memReq), 32'd1);
      checkOutput("flush mem_addr aligned", memAddr, 32'h200);
      waitFor(0, base + 3, "flush grant of 0x200");
      memGnt = 1'b0;
      waitFor(1, hsBase + 1, "flush delivery");
      checkOutput("flush addr queue drained", 32'(expAddrQ.size()), 32'd0);
      checkOutput("flush pc queue drained", 32'(expPcQ.size()), 32'd0);

      // Redirect in the same cycle the response arrives: no DISCARD stall.
      $display("[TB] redirect coincident with response");
      applyReset();
      memLat = 1;
      expAddrQ.push_back(32'h0); expAddrQ.push_back(32'h40);
      expPcQ.push_back(32'h40);
      base = grantCount; hsBase = hsCount;
      ifReady = 1'b1; memGnt = 1'b1;
      waitFor(0, base + 1, "coincident grant of 0x0");
      redirectValid = 1'b1; redirectTarget = 32'h40;
      @(negedge clk);
      checkOutput("coincident mem_req in redirect cycle", 32'(memReq), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      @(negedge clk);
      checkOutput("coincident mem_req next cycle", 32'(memReq), 32'd1);
      checkOutput("coincident mem_addr next cycle", memAddr, 32'h40);
      waitFor(0, base + 2, "coincident grant of 0x40");
      memGnt = 1'b0;
      waitFor(1, hsBase + 1, "coincident delivery");
      checkOutput("coincident addr queue drained", 32'(expAddrQ.size()), 32'd0);
      checkOutput("coincident pc queue drained", 32'(expPcQ.size()), 32'd0);

      // PC wrap from 0xFFFFFFFC, then reset while a request is outstanding.
      $display("[TB] pc wrap and reset in WAIT");
      applyReset();
      @(negedge clk);
      checkOutput("wrap reset mem_req", 32'(wMemReq), 32'd1);
      checkOutput("wrap reset mem_addr", wMemAddr, 32'hFFFF_FFFC);
      checkOutput("wrap reset if_valid", 32'(wIfValid), 32'd0);
      wExpAddrQ.push_back(32'hFFFF_FFFC); wExpAddrQ.push_back(32'h0);
      wExpPcQ.push_back(32'hFFFF_FFFC);   wExpPcQ.push_back(32'h0);
      base = wGrantCount; hsBase = wHsCount;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      wIfReady = 1'b1; wMemGnt = 1'b1;
      waitFor(2, base + 2, "wrap grants");
      wMemGnt = 1'b0;
      waitFor(3, hsBase + 2, "wrap deliveries");
      wExpAddrQ.push_back(32'h4);
      wMemGnt = 1'b1;
      waitFor(2, base + 3, "wrap grant of 0x4");
      reset = 1'b1; wMemGnt = 1'b0;
      @(negedge clk);
      checkOutput("wrap mem_req during reset", 32'(wMemReq), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("wrap after reset if_valid", 32'(wIfValid), 32'd0);
      checkOutput("wrap after reset mem_req", 32'(wMemReq), 32'd1);
      checkOutput("wrap after reset mem_addr", wMemAddr, 32'hFFFF_FFFC);
      checkOutput("wrap after reset if_pc", wIfPc, 32'd0);
      checkOutput("wrap after reset misalign_err", 32'(wMisalignErr), 32'd0);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      checkOutput("wrap no ghost push", 32'(wIfValid), 32'd0);
      checkOutput("wrap addr queue drained", 32'(wExpAddrQ.size()), 32'd0);
      checkOutput("wrap pc queue drained", 32'(wExpPcQ.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
